// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, instruction fetch and run/halt control
// for the 9-bit ISA core. The PC is presented to instruction memory
// directly, and the fetched word is qualified by state, range and halt decode.
module pc_fetch_unit #(
  parameter logic [31:0] START_ADDR = 32'd0,
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter logic [8:0]  HALT_INSTR = 9'h1FF,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic [31:0]          pc_in,
  input  logic [8:0]           imem_rdata,
  output logic [31:0]          imem_addr,
  output logic [31:0]          pc,
  output logic [31:0]          next_pc,
  output logic [8:0]           instruction,
  output logic                 valid,
  output logic                 done,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [31:0]          DEPTH   = 32'(IMEM_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 fault_q, fault_d;

  logic in_range;
  logic is_halt;

  assign in_range = (pc_q < DEPTH);
  assign is_halt  = (imem_rdata == HALT_INSTR);

  // State, PC, retired count and sticky fault registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_ADDR;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: stall freezes RUN entirely; an out-of-range PC is
  // checked before the halt decode because the fetched word is meaningless.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        pc_d = START_ADDR;
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          fault_d = 1'b0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (!in_range) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end else if (is_halt) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_in;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
          fault_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = START_ADDR;
      end
    endcase
  end

  // Outputs decoded from state and registers
  always_comb begin
    valid       = (state_q == S_RUN) && in_range && !is_halt;
    instruction = valid ? imem_rdata : 9'h000;
    done        = (state_q == S_HALT);
    fault       = fault_q;
    pc          = pc_q;
    imem_addr   = pc_q;
    next_pc     = pc_q + 32'd1;
    instr_count = cnt_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: straight-line program with halt,
// branch, stall, range fault, restart, mid-run reset and PC wrap.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic [31:0] pc_in;
  logic [8:0]  imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [8:0]  instruction;
  logic        valid;
  logic        done;
  logic        fault;
  logic [15:0] instr_count;

  logic [8:0]  mem [1024];
  logic        br_en;
  logic [31:0] br_tgt;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .pc_in(pc_in),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .pc(pc), .next_pc(next_pc),
    .instruction(instruction), .valid(valid), .done(done), .fault(fault),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Out-of-range reads return the halt encoding so range-vs-halt precedence is exercised
  assign imem_rdata = (imem_addr < 32'd1024) ? mem[imem_addr[9:0]] : 9'h1FF;
  assign pc_in      = br_en ? br_tgt : next_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 9'h001;
    mem[0] = 9'h011;
    mem[1] = 9'h022;
    mem[2] = 9'h033;
    mem[3] = 9'h1FF;
    reset = 1'b1; start = 1'b0; stall = 1'b0; br_en = 1'b0; br_tgt = 32'd0;
    #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("idle_pc", pc, 32'd0);
    chk("idle_valid", {31'd0, valid}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_cnt", {16'd0, instr_count}, 32'd0);

    // straight-line program halting at address 3
    start = 1'b1;
    step();
    start = 1'b0;
    chk("p_instr0", {23'd0, instruction}, 32'h011);
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      chk("p_pc", pc, 32'(i));
      if (valid) vcnt++;
      if (i == 1) chk("p_instr1", {23'd0, instruction}, 32'h022);
      if (i == 3) chk("p_halt_instr", {23'd0, instruction}, 32'd0);
      step();
    end
    chk("p_valid_cycles", 32'(vcnt), 32'd3);
    chk("p_done", {31'd0, done}, 32'd1);
    chk("p_halt_pc", pc, 32'd3);
    chk("p_cnt", {16'd0, instr_count}, 32'd3);
    step();
    chk("p_halt_hold", pc, 32'd3);

    // restart from HALT; start stays high into RUN and must be ignored
    mem[3] = 9'h044;
    start = 1'b1;
    step();
    chk("r_pc", pc, 32'd0);
    chk("r_cnt", {16'd0, instr_count}, 32'd0);
    chk("r_done", {31'd0, done}, 32'd0);
    step();
    chk("r_pc1", pc, 32'd1);
    br_en = 1'b1; br_tgt = 32'd10;
    step();
    br_en = 1'b0;
    chk("br_pc", pc, 32'd10);
    chk("br_cnt", {16'd0, instr_count}, 32'd2);
    stall = 1'b1;
    step(); step();
    stall = 1'b0;
    chk("st_pc", pc, 32'd10);
    chk("st_cnt", {16'd0, instr_count}, 32'd2);
    chk("st_next", next_pc, 32'd11);
    step();
    start = 1'b0;
    chk("ign_start_pc", pc, 32'd11);
    chk("ign_start_cnt", {16'd0, instr_count}, 32'd3);

    // range fault: branch to 5, then to IMEM_DEPTH
    br_en = 1'b1; br_tgt = 32'd5;
    step();
    chk("f_pc5", pc, 32'd5);
    br_tgt = 32'd1024;
    step();
    br_en = 1'b0;
    chk("f_pc_oob", pc, 32'd1024);
    chk("f_valid_oob", {31'd0, valid}, 32'd0);
    chk("f_instr_oob", {23'd0, instruction}, 32'd0);
    step();
    chk("f_fault", {31'd0, fault}, 32'd1);
    chk("f_done", {31'd0, done}, 32'd1);
    chk("f_instr", {23'd0, instruction}, 32'd0);
    chk("f_hold_pc", pc, 32'd1024);
    chk("f_cnt", {16'd0, instr_count}, 32'd5);

    // restart from faulted HALT; stall is ignored in HALT
    start = 1'b1; stall = 1'b1;
    step();
    start = 1'b0; stall = 1'b0;
    chk("rf_pc", pc, 32'd0);
    chk("rf_fault", {31'd0, fault}, 32'd0);
    chk("rf_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 7; i++) step();
    chk("mr_pc7", pc, 32'd7);
    chk("mr_cnt7", {16'd0, instr_count}, 32'd7);

    // asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    chk("ar_pc", pc, 32'd0);
    chk("ar_valid", {31'd0, valid}, 32'd0);
    chk("ar_cnt", {16'd0, instr_count}, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("ar_idle_pc", pc, 32'd0);
    chk("ar_idle_valid", {31'd0, valid}, 32'd0);
    chk("ar_idle_done", {31'd0, done}, 32'd0);

    // PC at the top of the address space: next_pc wraps, pc faults
    start = 1'b1;
    step();
    start = 1'b0;
    br_en = 1'b1; br_tgt = 32'hFFFF_FFFF;
    step();
    br_en = 1'b0;
    chk("w_pc", pc, 32'hFFFF_FFFF);
    chk("w_next", next_pc, 32'd0);
    chk("w_valid", {31'd0, valid}, 32'd0);
    step();
    chk("w_fault", {31'd0, fault}, 32'd1);
    chk("w_done", {31'd0, done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
